seg7_scan_ctrl: RTL

//   Time-multiplexed scan controller for a common-bus 7-segment display.

---
 rtl/seg7_scan_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-bus 7-segment display.
// Double-buffered BCD digits, blank gap between digits, registered pad outputs.
module seg7_scan_ctrl #(
    parameter int N_DIGITS     = 6,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic [4*N_DIGITS-1:0] i_bcd,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_load,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_digit,
    output logic                  o_frame_done,
    output logic                  o_dbg_state
);

    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(N_DIGITS);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [4*N_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*N_DIGITS-1:0] shad_bcd_q, shad_bcd_d;
    logic [N_DIGITS-1:0]   shad_dp_q, shad_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   digit_q, digit_d;
    logic                  fd_q, fd_d;

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        pend_bcd_d = pend_bcd_q;
        pend_dp_d  = pend_dp_q;
        shad_bcd_d = shad_bcd_q;
        shad_dp_d  = shad_dp_q;
        fd_d       = 1'b0;
        seg_d      = 7'b0;
        dp_d       = 1'b0;
        digit_d    = '0;

        if (i_load) begin
            pend_bcd_d = i_bcd;
            pend_dp_d  = i_dp;
        end

        // fd_q marks the wrap cycle; a load landing on it bypasses pending.
        if (!i_en || fd_q) begin
            shad_bcd_d = i_load ? i_bcd : pend_bcd_q;
            shad_dp_d  = i_load ? i_dp  : pend_dp_q;
        end

        if (!i_en) begin
            state_d = ST_BLANK;
            idx_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (timer_q == TW'(BLANK_CYCLES - 1)) begin
                        state_d = ST_ON;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_ON: begin
                    if (timer_q == TW'(DWELL_CYCLES - 1)) begin
                        state_d = ST_BLANK;
                        timer_d = '0;
                        if (idx_q == IW'(N_DIGITS - 1)) begin
                            idx_d = '0;
                            fd_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    timer_d = '0;
                end
            endcase
        end

        // Outputs are decoded from next-state so segments and enable move together.
        if (state_d == ST_ON) begin
            digit_d[idx_d] = 1'b1;
            seg_d          = enc(shad_bcd_d[4*idx_d +: 4]);
            dp_d           = shad_dp_d[idx_d];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_BLANK;
            idx_q      <= '0;
            timer_q    <= '0;
            pend_bcd_q <= '1;
            pend_dp_q  <= '0;
            shad_bcd_q <= '1;
            shad_dp_q  <= '0;
            seg_q      <= 7'b0;
            dp_q       <= 1'b0;
            digit_q    <= '0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            pend_bcd_q <= pend_bcd_d;
            pend_dp_q  <= pend_dp_d;
            shad_bcd_q <= shad_bcd_d;
            shad_dp_q  <= shad_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            digit_q    <= digit_d;
            fd_q       <= fd_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_dp         = dp_q;
    assign o_digit      = digit_q;
    assign o_frame_done = fd_q;
    assign o_dbg_state  = state_q;

endmodule
